intr_seq: RTL and testbench
===========================

# intr_seq

Interrupt/reset sequencer for the address-bus generator. It owns `ab_op` during reset start-up, NMI, IRQ and BRK. It drives the stack pushes of PCH, PCL and P at page 1, loads the vector selector into PC, fetches the two vector bytes and jumps. The core muxes `ab_op` from this block whenever `busy`=1 and from its own decoder otherwise.

## Interface
- `RST_DUMMY`, default 3: number of dummy stack cycles after reset release (each decrements S, no write). Legal range 1..7.
- `clk` in 1: system clock; everything is posedge.
- `RST` in 1: synchronous, active-high reset.
- `sync` in 1: instruction boundary (opcode fetch cycle) from the core.
- `brk` in 1: one-cycle strobe from the decoder, BRK opcode decoded. Never coincides with `sync`.
- `nmi` in 1: NMI level, active-high; a rising edge latches the request.
- `irq` in 1: IRQ level, active-high.
- `i_flag` in 1: P.I; 1 masks IRQ.
- `ab_op` out 10: address-bus operation word for the address generator.
- `busy` out 1: the sequencer owns the address bus.
- `we` out 1: memory write strobe.
- `do_sel` out 2: write data select: 00=PCH, 01=PCL, 10=P.
- `b_flag` out 1: B bit value for the P push (1 only for BRK).
- `s_dec` out 1: decrement S at the end of this cycle.
- `set_i` out 1: set P.I at the end of this cycle.
- `dr_load` out 1: DR <= DI at the end of this cycle.
- `done` out 1: one-cycle pulse in the last sequence cycle.

## Operation
- States: RST_HOLD, RDUM, PUSH_H, PUSH_L, PUSH_P, VEC_L, VEC_H, JUMP, IDLE.
- `ab_op` constants per state:
  - stack access `{00,S}+0x0100` = 0x100
  - PC-load NMI 0x140, IRQ/BRK 0x160
  - VEC_L (base PC, +0) = 0x008
  - VEC_H (base PC, ci=1, carry into high byte) = 0x209
  - JUMP (base {DI,DR}, PC<=AB+1) = 0x030
  - IDLE/RST_HOLD = 0x000
- Reset path: RST_HOLD → RDUM ×`RST_DUMMY` → VEC_L → VEC_H → JUMP → IDLE.
  - RDUM: `ab_op`=0x100, `s_dec`=1, `we`=0.
  - PC is already 0xFFFC from the generator's own reset, so no PC-load cycle is used.
- Interrupt path: IDLE → PUSH_H → PUSH_L → PUSH_P → VEC_L → VEC_H → JUMP → IDLE.
  - Each push cycle: `we`=1, `s_dec`=1, `do_sel` per push.
  - PUSH_P: `ab_op`=0x140 (NMI) or 0x160 (IRQ/BRK); the vector selector is loaded into PC at the end of the cycle.
  - VEC_L: `set_i`=1.
  - VEC_H: `dr_load`=1, capturing the low vector byte returned for VEC_L.
  - JUMP: `done`=1; the target is on AB and PC <= target+1.
- Acceptance is evaluated only in IDLE. Priority, highest first:
  - NMI pending, when `sync` or `brk`
  - IRQ, when `sync` & `irq` & !`i_flag`
  - BRK, when `brk`
- NMI latch:
  - `nmi_pend` is set on a 0→1 edge of `nmi`, sampled against a registered copy.
  - It is cleared on entry to PUSH_H for an NMI sequence.
  - An edge arriving during any sequence stays pending; set and clear in the same cycle resolves as set.
- BRK hijack: `brk` with `nmi_pend`=1 runs the NMI sequence with `b_flag`=1 and clears `nmi_pend`.
- `b_flag`=1 through the whole sequence for BRK (including hijack), 0 otherwise.

## Timing
- During RST=1:
  - state RST_HOLD; `nmi_pend` and the `nmi` history register are cleared.
  - Outputs: `busy`=1, `ab_op`=0x000, and `we`, `s_dec`, `set_i`, `dr_load`, `done`, `b_flag`=0, `do_sel`=00.
- RST asserted in any state aborts the current sequence at the next edge.
- First cycle after RST falls is RDUM #1. The reset vector target appears on AB in cycle `RST_DUMMY`+3 (6 with the default); `busy` falls the cycle after.
- Interrupt latency:
  - acceptance cycle (IDLE, `busy`=0) → PUSH_H on the next cycle.
  - Exactly 6 busy cycles, then IDLE. Back-to-back acceptance is possible from the IDLE cycle that follows.
- All outputs are Moore (decoded from registered state plus registered kind). No combinational path from inputs to outputs.

## Test plan
- Reset, `RST_DUMMY`=3, memory FFFC=0x34, FFFD=0x12:
  - RST 2 cycles → `busy`=1 and `ab_op`=0x000 while RST high.
  - Then 3 cycles of `ab_op`=0x100 with `s_dec`=1 and `we`=0.
  - Then 0x008, 0x209, 0x030 with AB=0x1234, `done`=1, and PC=0x1235 the next cycle.
- IRQ with `i_flag`=0, `sync` pulse:
  - `we`=1 for 3 cycles with `do_sel` 00, 01, 10 and `b_flag`=0.
  - PUSH_P `ab_op`=0x160, `set_i` in VEC_L.
- IRQ masked (`i_flag`=1, `irq`=1, `sync` repeatedly) → `busy` stays 0. Clearing `i_flag` → the sequence starts after the next `sync`.
- NMI edge during an IRQ sequence:
  - The IRQ sequence completes unchanged.
  - The next `sync` starts the NMI sequence with `ab_op`=0x140 in PUSH_P.
  - Holding `nmi` high triggers no second NMI.
- BRK hijack: `nmi` edge, then `brk` before any `sync` → NMI vector (0x140), `b_flag`=1 on all push cycles, `nmi_pend` cleared.
- RST asserted in PUSH_L → `we` drops next cycle, and the full reset sequence follows release.

Source files
------------

// File: rtl/intr_seq.sv
// Interrupt/reset sequencer: owns the address-bus operation word during reset
// start-up, NMI, IRQ and BRK, driving the stack pushes, vector fetch and jump.
module intr_seq #(
    parameter int RST_DUMMY = 3
) (
    input  logic       clk,
    input  logic       RST,
    input  logic       sync,
    input  logic       brk,
    input  logic       nmi,
    input  logic       irq,
    input  logic       i_flag,
    output logic [9:0] ab_op,
    output logic       busy,
    output logic       we,
    output logic [1:0] do_sel,
    output logic       b_flag,
    output logic       s_dec,
    output logic       set_i,
    output logic       dr_load,
    output logic       done
);

    typedef enum logic [3:0] {
        RST_HOLD,
        RDUM,
        PUSH_H,
        PUSH_L,
        PUSH_P,
        VEC_L,
        VEC_H,
        JUMP,
        IDLE
    } state_t;

    localparam logic [9:0] AB_NONE  = 10'h000;
    localparam logic [9:0] AB_STACK = 10'h100;
    localparam logic [9:0] AB_VNMI  = 10'h140;
    localparam logic [9:0] AB_VIRQ  = 10'h160;
    localparam logic [9:0] AB_VECL  = 10'h008;
    localparam logic [9:0] AB_VECH  = 10'h209;
    localparam logic [9:0] AB_JUMP  = 10'h030;

    localparam logic [2:0] DUM_LAST = 3'(RST_DUMMY);

    state_t     state, state_nx;
    logic [2:0] dum_cnt;
    logic       vec_nmi;   // sequence uses the NMI vector
    logic       brk_kind;  // sequence was started by a BRK opcode
    logic       nmi_q;
    logic       nmi_pend;

    logic accept_nmi, accept_irq, accept;
    logic nmi_edge, take_nmi;

    assign nmi_edge   = nmi & ~nmi_q;
    assign accept_nmi = nmi_pend & (sync | brk);
    assign accept_irq = sync & irq & ~i_flag;
    assign accept     = accept_nmi | accept_irq | brk;
    assign take_nmi   = (state == IDLE) & accept_nmi;

    // NOTE: all state uses non-blocking assignments so every register samples
    // the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (RST) begin
            state    <= RST_HOLD;
            dum_cnt  <= 3'd0;
            vec_nmi  <= 1'b0;
            brk_kind <= 1'b0;
            nmi_q    <= 1'b0;
            nmi_pend <= 1'b0;
        end else begin
            state    <= state_nx;
            nmi_q    <= nmi;
            // A new edge wins over the clear issued in the same cycle.
            nmi_pend <= nmi_edge | (nmi_pend & ~take_nmi);
            if (state == RST_HOLD)
                dum_cnt <= 3'd1;
            else if (state == RDUM)
                dum_cnt <= dum_cnt + 3'd1;
            if (state == IDLE && accept) begin
                vec_nmi  <= accept_nmi;
                brk_kind <= brk;
            end
        end
    end

    always_comb begin
        state_nx = state;
        ab_op    = AB_NONE;
        busy     = 1'b1;
        we       = 1'b0;
        do_sel   = 2'b00;
        b_flag   = 1'b0;
        s_dec    = 1'b0;
        set_i    = 1'b0;
        dr_load  = 1'b0;
        done     = 1'b0;
        case (state)
            RST_HOLD: state_nx = RDUM;
            RDUM: begin
                ab_op    = AB_STACK;
                s_dec    = 1'b1;
                state_nx = (dum_cnt == DUM_LAST) ? VEC_L : RDUM;
            end
            PUSH_H: begin
                ab_op    = AB_STACK;
                we       = 1'b1;
                s_dec    = 1'b1;
                do_sel   = 2'b00;
                b_flag   = brk_kind;
                state_nx = PUSH_L;
            end
            PUSH_L: begin
                ab_op    = AB_STACK;
                we       = 1'b1;
                s_dec    = 1'b1;
                do_sel   = 2'b01;
                b_flag   = brk_kind;
                state_nx = PUSH_P;
            end
            PUSH_P: begin
                ab_op    = vec_nmi ? AB_VNMI : AB_VIRQ;
                we       = 1'b1;
                s_dec    = 1'b1;
                do_sel   = 2'b10;
                b_flag   = brk_kind;
                state_nx = VEC_L;
            end
            VEC_L: begin
                ab_op    = AB_VECL;
                set_i    = 1'b1;
                b_flag   = brk_kind;
                state_nx = VEC_H;
            end
            VEC_H: begin
                ab_op    = AB_VECH;
                dr_load  = 1'b1;
                b_flag   = brk_kind;
                state_nx = JUMP;
            end
            JUMP: begin
                ab_op    = AB_JUMP;
                done     = 1'b1;
                b_flag   = brk_kind;
                state_nx = IDLE;
            end
            IDLE: begin
                busy     = 1'b0;
                state_nx = accept ? PUSH_H : IDLE;
            end
            default: state_nx = RST_HOLD;
        endcase
    end

endmodule

// File: tb/tb_intr_seq.sv
// Directed bench for intr_seq: a scoreboard of expected per-cycle outputs plus a
// small address-generator model that checks the jump target and final PC.
module tb_intr_seq;

    localparam int RST_DUMMY = 3;

    logic       clk = 1'b0;
    logic       RST, sync, brk, nmi, irq, i_flag;
    logic [9:0] ab_op;
    logic       busy, we, b_flag, s_dec, set_i, dr_load, done;
    logic [1:0] do_sel;

    intr_seq #(.RST_DUMMY(RST_DUMMY)) dut (
        .clk(clk), .RST(RST), .sync(sync), .brk(brk), .nmi(nmi), .irq(irq),
        .i_flag(i_flag), .ab_op(ab_op), .busy(busy), .we(we), .do_sel(do_sel),
        .b_flag(b_flag), .s_dec(s_dec), .set_i(set_i), .dr_load(dr_load),
        .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       busy;
        logic [9:0] ab_op;
        logic       we;
        logic [1:0] do_sel;
        logic       b_flag;
        logic       s_dec;
        logic       set_i;
        logic       dr_load;
        logic       done;
    } exp_t;

    typedef struct {
        string       tag;
        exp_t        o;
        bit          chk_ab;
        logic [15:0] ab;
        bit          chk_pc;
        logic [15:0] pc;
    } sb_t;

    sb_t sb[$];
    int  n_vec = 0;
    int  n_err = 0;

    // Address generator model driven only by ab_op, with a one-cycle read memory.
    logic [15:0] m_pc, m_ab;
    logic [7:0]  m_s, m_di, m_dr;

    function automatic logic [7:0] mem_rd(logic [15:0] a);
        case (a)
            16'hFFFA: return 8'hBC;
            16'hFFFB: return 8'h9A;
            16'hFFFC: return 8'h34;
            16'hFFFD: return 8'h12;
            16'hFFFE: return 8'h78;
            16'hFFFF: return 8'h56;
            default:  return 8'h00;
        endcase
    endfunction

    always_comb begin
        case (ab_op)
            10'h100, 10'h140, 10'h160: m_ab = {8'h01, m_s};
            10'h008:                   m_ab = m_pc;
            10'h209:                   m_ab = m_pc + 16'd1;
            10'h030:                   m_ab = {m_di, m_dr};
            default:                   m_ab = m_pc;
        endcase
    end

    always @(posedge clk) begin
        if (RST) begin
            m_pc <= 16'hFFFC;
            m_s  <= 8'h00;
            m_di <= 8'h00;
            m_dr <= 8'h00;
        end else begin
            m_di <= mem_rd(m_ab);
            if (dr_load) m_dr <= m_di;
            if (s_dec)   m_s  <= m_s - 8'd1;
            case (ab_op)
                10'h140: m_pc <= 16'hFFFA;
                10'h160: m_pc <= 16'hFFFE;
                10'h030: m_pc <= m_ab + 16'd1;
                default: ;
            endcase
        end
    end

    function automatic exp_t mk(logic bz, logic [9:0] op, logic w, logic [1:0] ds,
                                logic b, logic sd, logic si, logic dl, logic dn);
        return {bz, op, w, ds, b, sd, si, dl, dn};
    endfunction

    task automatic push(string tag, exp_t o, bit chk_ab = 0, logic [15:0] ab = 16'h0,
                        bit chk_pc = 0, logic [15:0] pc = 16'h0);
        sb_t e;
        e.tag = tag; e.o = o; e.chk_ab = chk_ab; e.ab = ab; e.chk_pc = chk_pc; e.pc = pc;
        sb.push_back(e);
    endtask

    task automatic push_idle(string tag);
        push(tag, mk(0, 10'h000, 0, 2'b00, 0, 0, 0, 0, 0));
    endtask

    task automatic push_hold();
        push("rst_hold", mk(1, 10'h000, 0, 2'b00, 0, 0, 0, 0, 0));
    endtask

    task automatic push_reset_seq();
        for (int i = 0; i < RST_DUMMY; i++)
            push("rdum", mk(1, 10'h100, 0, 2'b00, 0, 1, 0, 0, 0));
        push("rst_vec_l", mk(1, 10'h008, 0, 2'b00, 0, 0, 1, 0, 0));
        push("rst_vec_h", mk(1, 10'h209, 0, 2'b00, 0, 0, 0, 1, 0));
        push("rst_jump",  mk(1, 10'h030, 0, 2'b00, 0, 0, 0, 0, 1), 1, 16'h1234);
        push("rst_idle",  mk(0, 10'h000, 0, 2'b00, 0, 0, 0, 0, 0), 0, 16'h0, 1, 16'h1235);
    endtask

    task automatic push_int_seq(bit is_nmi, bit b, logic [15:0] tgt);
        logic [9:0] vop;
        vop = is_nmi ? 10'h140 : 10'h160;
        push("push_h", mk(1, 10'h100, 1, 2'b00, b, 1, 0, 0, 0));
        push("push_l", mk(1, 10'h100, 1, 2'b01, b, 1, 0, 0, 0));
        push("push_p", mk(1, vop,     1, 2'b10, b, 1, 0, 0, 0));
        push("vec_l",  mk(1, 10'h008, 0, 2'b00, b, 0, 1, 0, 0));
        push("vec_h",  mk(1, 10'h209, 0, 2'b00, b, 0, 0, 1, 0));
        push("jump",   mk(1, 10'h030, 0, 2'b00, b, 0, 0, 0, 1), 1, tgt);
        push("idle",   mk(0, 10'h000, 0, 2'b00, 0, 0, 0, 0, 0), 0, 16'h0, 1, tgt + 16'd1);
    endtask

    // Advance to the next falling edge and compare against the scoreboard head.
    task automatic tick();
        sb_t  e;
        exp_t obs;
        @(negedge clk);
        if (sb.size() > 0) begin
            e   = sb.pop_front();
            obs = {busy, ab_op, we, do_sel, b_flag, s_dec, set_i, dr_load, done};
            n_vec++;
            assert (obs === e.o) else begin
                n_err++;
                $error("FAIL %s: outputs got %h expected %h", e.tag, obs, e.o);
            end
            if (e.chk_ab) begin
                n_vec++;
                assert (m_ab === e.ab) else begin
                    n_err++;
                    $error("FAIL %s_ab: got %h expected %h", e.tag, m_ab, e.ab);
                end
            end
            if (e.chk_pc) begin
                n_vec++;
                assert (m_pc === e.pc) else begin
                    n_err++;
                    $error("FAIL %s_pc: got %h expected %h", e.tag, m_pc, e.pc);
                end
            end
        end
    endtask

    task automatic run(int n);
        repeat (n) tick();
    endtask

    initial begin
        RST = 1'b1; sync = 1'b0; brk = 1'b0; nmi = 1'b0; irq = 1'b0; i_flag = 1'b0;

        // Reset start-up and reset-vector fetch.
        push_hold(); push_hold();
        run(2);
        RST = 1'b0;
        push_reset_seq();
        run(RST_DUMMY + 4);

        // Unmasked IRQ on an instruction boundary.
        irq = 1'b1; sync = 1'b1;
        push_int_seq(0, 0, 16'h5678);
        tick();
        sync = 1'b0; irq = 1'b0;
        run(6);

        // Masked IRQ never starts; unmasking takes effect on the next sync.
        i_flag = 1'b1; irq = 1'b1;
        repeat (3) begin
            sync = 1'b1; push_idle("irq_masked"); tick();
            sync = 1'b0; push_idle("irq_masked"); tick();
        end
        i_flag = 1'b0;
        push_idle("irq_unmask_nosync"); tick();
        sync = 1'b1;
        push_int_seq(0, 0, 16'h5678);
        tick();
        sync = 1'b0; irq = 1'b0;
        run(6);

        // NMI edge during an IRQ sequence stays pending until the next sync.
        irq = 1'b1; sync = 1'b1;
        push_int_seq(0, 0, 16'h5678);
        tick();
        sync = 1'b0; irq = 1'b0; nmi = 1'b1;
        run(6);
        sync = 1'b1;
        push_int_seq(1, 0, 16'h9ABC);
        tick();
        sync = 1'b0;
        run(6);
        repeat (2) begin
            sync = 1'b1; push_idle("nmi_held"); tick();
            sync = 1'b0; push_idle("nmi_held"); tick();
        end
        nmi = 1'b0;
        push_idle("nmi_release"); tick();

        // BRK hijacked by a pending NMI, then a plain BRK.
        nmi = 1'b1;
        push_idle("nmi_edge"); tick();
        brk = 1'b1;
        push_int_seq(1, 1, 16'h9ABC);
        tick();
        brk = 1'b0;
        run(6);
        sync = 1'b1; push_idle("hijack_cleared"); tick();
        sync = 1'b0; push_idle("hijack_cleared"); tick();
        nmi = 1'b0;
        brk = 1'b1;
        push_int_seq(0, 1, 16'h5678);
        tick();
        brk = 1'b0;
        run(6);

        // Reset during PUSH_L aborts the sequence and restarts from reset.
        irq = 1'b1; sync = 1'b1;
        push("abort_push_h", mk(1, 10'h100, 1, 2'b00, 0, 1, 0, 0, 0));
        tick();
        sync = 1'b0; irq = 1'b0;
        push("abort_push_l", mk(1, 10'h100, 1, 2'b01, 0, 1, 0, 0, 0));
        tick();
        RST = 1'b1;
        push_hold();
        tick();
        RST = 1'b0;
        push_reset_seq();
        run(RST_DUMMY + 4);

        n_vec++;
        assert (sb.size() == 0) else begin
            n_err++;
            $error("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
